retire_order: RTL and testbench

- Back end of the dual-issue steering path: accepts the two pipe completions at writeback and restores program order.
- Each completion is tagged with the instruction id from the steering stage: group = id >> `NUM_BITS_PIPE_ID`; the low bits are the pipe tag.
- Drops NOP slots and buffers real instructions in a small circular FIFO.
- Presents one retired instruction per cycle on a valid/ready commit port (trace logger / architectural commit counter), with back-pressure to the pipeline and sticky ordering-error detection.

---
 rtl/retire_order_pkg.sv | 34 +++
 rtl/retire_order_if.sv | 37 +++
 rtl/retire_order_fifo.sv | 65 ++++++
 rtl/retire_order.sv | 111 +++++++++++
 tb/tb_retire_order.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/retire_order_pkg.sv
// Shared widths, encodings and retire-entry layout for the writeback reorder path.
// The global defines live here so every later file in the bundle sees them.
`ifndef RETIRE_GLOBAL_DEFINES
`define RETIRE_GLOBAL_DEFINES
`define INST_WIDTH            32
`define ADDR_WIDTH            32
`define INSTRUCTION_ID_WIDTH  8
`define NUM_BITS_PIPE_ID      1
`define PIPE_ID1              1'b0
`define PIPE_ID2              1'b1
`define NOP_INSTRUCTION       32'h0000_0013
`define RETIRE_ENTRY_WIDTH    (`INST_WIDTH + `ADDR_WIDTH + `INSTRUCTION_ID_WIDTH)
`define RETIRE_COUNT_WIDTH    32
`endif

package retire_order_pkg;
   localparam int ID_W    = `INSTRUCTION_ID_WIDTH;
   localparam int TAG_W   = `NUM_BITS_PIPE_ID;
   localparam int GROUP_W = ID_W - TAG_W;

   typedef struct packed {
      logic [`INST_WIDTH-1:0]           inst;
      logic [`ADDR_WIDTH-1:0]           pc;
      logic [`INSTRUCTION_ID_WIDTH-1:0] id;
   } retire_entry_t;

   // Wrap-safe: new is younger when (new - last) is nonzero with a clear sign bit.
   function automatic logic id_younger(input logic [ID_W-1:0] new_id,
                                       input logic [ID_W-1:0] last_id);
      logic [ID_W-1:0] diff;
      diff = new_id - last_id;
      return (diff != '0) && !diff[ID_W-1];
   endfunction
endpackage

// File: rtl/retire_order_if.sv
// Pipe completion inputs, flush, and the valid/ready commit port of retire_order.
interface retire_order_if;
   logic                              pipe0_valid;
   logic [`INST_WIDTH-1:0]            pipe0_instruction;
   logic [`ADDR_WIDTH-1:0]            pipe0_pc;
   logic [`INSTRUCTION_ID_WIDTH-1:0]  pipe0_id;
   logic                              pipe1_valid;
   logic [`INST_WIDTH-1:0]            pipe1_instruction;
   logic [`ADDR_WIDTH-1:0]            pipe1_pc;
   logic [`INSTRUCTION_ID_WIDTH-1:0]  pipe1_id;
   logic                              flush;
   logic                              retire_valid;
   logic                              retire_ready;
   logic [`INST_WIDTH-1:0]            retire_instruction;
   logic [`ADDR_WIDTH-1:0]            retire_pc;
   logic [`INSTRUCTION_ID_WIDTH-1:0]  retire_id;
   logic                              retire_stall;
   logic                              overflow;
   logic                              order_error;
   logic [`RETIRE_COUNT_WIDTH-1:0]    retired_count;

   modport master (
      output pipe0_valid, pipe0_instruction, pipe0_pc, pipe0_id,
      output pipe1_valid, pipe1_instruction, pipe1_pc, pipe1_id,
      output flush, retire_ready,
      input  retire_valid, retire_instruction, retire_pc, retire_id,
      input  retire_stall, overflow, order_error, retired_count
   );

   modport slave (
      input  pipe0_valid, pipe0_instruction, pipe0_pc, pipe0_id,
      input  pipe1_valid, pipe1_instruction, pipe1_pc, pipe1_id,
      input  flush, retire_ready,
      output retire_valid, retire_instruction, retire_pc, retire_id,
      output retire_stall, overflow, order_error, retired_count
   );
endinterface

// File: rtl/retire_order_fifo.sv
// Dual-write single-read circular buffer; accepts as many writes as space allows.
module retire_fifo #(
   parameter  int DEPTH    = 4,
   parameter  int W        = 8,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic [1:0]          wr_count,
   input  logic [W-1:0]        wr_data0,
   input  logic [W-1:0]        wr_data1,
   input  logic                rd_en,
   output logic [1:0]          wr_accepted,
   output logic [PTR_BITS:0]   count,
   output logic [W-1:0]        rd_data
);
   logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_BITS:0]   count_q, count_d;
   logic [PTR_BITS+1:0] space;
   logic [W-1:0]        mem_q [DEPTH];
   logic [W-1:0]        mem_d [DEPTH];
   logic                do_rd;

   always_comb begin
      do_rd = rd_en && (count_q != '0);
      // A pop in the same cycle frees its slot for this cycle's writes.
      space = (PTR_BITS+2)'(DEPTH) - {1'b0, count_q} + (PTR_BITS+2)'(do_rd);
      wr_accepted = wr_count;
      if ((PTR_BITS+2)'(wr_count) > space) wr_accepted = space[1:0];
      if (flush) wr_accepted = 2'd0;

      mem_d = mem_q;
      if (wr_accepted != 2'd0) mem_d[tail_q] = wr_data0;
      if (wr_accepted == 2'd2) mem_d[tail_q + PTR_BITS'(1)] = wr_data1;

      head_d  = head_q + PTR_BITS'(do_rd);
      tail_d  = tail_q + PTR_BITS'(wr_accepted);
      count_d = count_q + (PTR_BITS+1)'(wr_accepted) - (PTR_BITS+1)'(do_rd);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count   = count_q;
   assign rd_data = mem_q[head_q];
endmodule

// File: rtl/retire_order.sv
// Restores program order of the two writeback completions, drops NOPs, and
// retires one buffered instruction per cycle with sticky overflow/order flags.
module retire_order
   import retire_order_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int PTR_BITS   = $clog2(FIFO_DEPTH)
) (
   input logic          clk,
   input logic          reset,
   retire_order_if.slave bus
);
   retire_entry_t        e0, e1, e_a, e_b, head;
   logic                 cand0, cand1, p1_first, pop;
   logic [1:0]           req, acc;
   logic [PTR_BITS:0]    count;
   logic [GROUP_W-1:0]   grp0, grp1, grp_diff;
   logic                 overflow_q, overflow_d, order_error_q, order_error_d;
   logic                 last_vld_q, last_vld_d;
   logic [ID_W-1:0]      last_id_q, last_id_d;
   logic [`RETIRE_COUNT_WIDTH-1:0] retired_count_q, retired_count_d;

   always_comb begin
      e0 = '{inst: bus.pipe0_instruction, pc: bus.pipe0_pc, id: bus.pipe0_id};
      e1 = '{inst: bus.pipe1_instruction, pc: bus.pipe1_pc, id: bus.pipe1_id};
      cand0 = bus.pipe0_valid && (bus.pipe0_instruction != `NOP_INSTRUCTION);
      cand1 = bus.pipe1_valid && (bus.pipe1_instruction != `NOP_INSTRUCTION);

      grp0     = bus.pipe0_id[ID_W-1:TAG_W];
      grp1     = bus.pipe1_id[ID_W-1:TAG_W];
      grp_diff = grp0 - grp1;
      if (grp0 != grp1) p1_first = !grp_diff[GROUP_W-1];
      else p1_first = (bus.pipe1_id != bus.pipe0_id) &&
                      (bus.pipe1_id[TAG_W-1:0] == `PIPE_ID1);

      e_a = e0;
      e_b = e1;
      req = 2'd0;
      if (!bus.flush) begin
         if (cand0 && cand1) begin
            req = 2'd2;
            if (p1_first) begin
               e_a = e1;
               e_b = e0;
            end
         end else if (cand0) begin
            req = 2'd1;
         end else if (cand1) begin
            req = 2'd1;
            e_a = e1;
         end
      end

      pop = (count != '0) && bus.retire_ready;

      overflow_d      = overflow_q || (acc < req);
      order_error_d   = order_error_q;
      last_id_d       = last_id_q;
      last_vld_d      = last_vld_q;
      retired_count_d = retired_count_q + `RETIRE_COUNT_WIDTH'(pop);
      if (req == 2'd2 && bus.pipe0_id == bus.pipe1_id) order_error_d = 1'b1;
      if (acc != 2'd0) begin
         if (last_vld_q && !id_younger(e_a.id, last_id_q)) order_error_d = 1'b1;
         last_id_d  = e_a.id;
         last_vld_d = 1'b1;
      end
      if (acc == 2'd2) begin
         if (!id_younger(e_b.id, e_a.id)) order_error_d = 1'b1;
         last_id_d = e_b.id;
      end
      if (bus.flush) last_vld_d = 1'b0;
   end

   retire_fifo #(.DEPTH(FIFO_DEPTH), .W(`RETIRE_ENTRY_WIDTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush       (bus.flush),
      .wr_count    (req),
      .wr_data0    (e_a),
      .wr_data1    (e_b),
      .rd_en       (pop),
      .wr_accepted (acc),
      .count       (count),
      .rd_data     (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q      <= 1'b0;
         order_error_q   <= 1'b0;
         last_vld_q      <= 1'b0;
         last_id_q       <= '0;
         retired_count_q <= '0;
      end else begin
         overflow_q      <= overflow_d;
         order_error_q   <= order_error_d;
         last_vld_q      <= last_vld_d;
         last_id_q       <= last_id_d;
         retired_count_q <= retired_count_d;
      end
   end

   assign bus.retire_valid       = (count != '0);
   assign bus.retire_instruction = head.inst;
   assign bus.retire_pc          = head.pc;
   assign bus.retire_id          = head.id;
   assign bus.retire_stall       = count > (PTR_BITS+1)'(FIFO_DEPTH - 2);
   assign bus.overflow           = overflow_q;
   assign bus.order_error        = order_error_q;
   assign bus.retired_count      = retired_count_q;
endmodule

// File: tb/tb_retire_order.sv
// Directed bench for retire_order: ordering, NOP drop, overflow, flush, id wrap.
module tb_retire_order;
   import retire_order_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   retire_order_if bus();
   retire_order #(.FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [7:0] id0, input logic [31:0] pc0,
                        input logic v1, input logic [7:0] id1, input logic [31:0] pc1);
      bus.pipe0_valid = v0; bus.pipe0_id = id0; bus.pipe0_pc = pc0;
      bus.pipe0_instruction = 32'hA000_0000 | pc0;
      bus.pipe1_valid = v1; bus.pipe1_id = id1; bus.pipe1_pc = pc1;
      bus.pipe1_instruction = 32'hA000_0000 | pc1;
   endtask

   task automatic idle();
      drive(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic do_reset();
      idle();
      bus.flush = 1'b0;
      bus.retire_ready = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      drive(1'b1, 8'd4, 32'h99, 1'b1, 8'd5, 32'h98);
      bus.flush = 1'b0;
      bus.retire_ready = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      total++; if (bus.retire_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.retire_valid); end
      total++; if (bus.retire_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.retire_stall); end
      total++; if ({bus.overflow, bus.order_error} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {bus.overflow, bus.order_error}); end
      total++; if (bus.retired_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.retired_count); end
   endtask

   task automatic test_same_group();
      do_reset();
      bus.retire_ready = 1'b1;
      drive(1'b1, 8'd11, 32'h11, 1'b1, 8'd10, 32'h10);
      step();
      idle();
      total++; if (bus.retire_valid !== 1'b1 || bus.retire_pc !== 32'h10) begin bad++; $display("FAIL grp_first got=%b/%h exp=1/10", bus.retire_valid, bus.retire_pc); end
      step();
      total++; if (bus.retire_pc !== 32'h11 || bus.retired_count !== 32'd1) begin bad++; $display("FAIL grp_second got=%h/%0d exp=11/1", bus.retire_pc, bus.retired_count); end
      step();
      total++; if (bus.retire_valid !== 1'b0 || bus.retired_count !== 32'd2) begin bad++; $display("FAIL grp_done got=%b/%0d exp=0/2", bus.retire_valid, bus.retired_count); end
      drive(1'b1, 8'd16, 32'h41, 1'b1, 8'd15, 32'h40);
      step();
      idle();
      total++; if (bus.retire_pc !== 32'h40) begin bad++; $display("FAIL diffgrp_first got=%h exp=40", bus.retire_pc); end
      step();
      total++; if (bus.retire_pc !== 32'h41) begin bad++; $display("FAIL diffgrp_second got=%h exp=41", bus.retire_pc); end
      step();
      total++; if (bus.order_error !== 1'b0 || bus.retired_count !== 32'd4) begin bad++; $display("FAIL diffgrp_end got=%b/%0d exp=0/4", bus.order_error, bus.retired_count); end
   endtask

   task automatic test_nop();
      do_reset();
      bus.retire_ready = 1'b1;
      drive(1'b1, 8'd12, 32'h0, 1'b1, 8'd13, 32'h20);
      bus.pipe0_instruction = 32'h0000_0013;
      step();
      idle();
      total++; if (bus.retire_valid !== 1'b1 || bus.retire_pc !== 32'h20) begin bad++; $display("FAIL nop_head got=%b/%h exp=1/20", bus.retire_valid, bus.retire_pc); end
      step();
      total++; if (bus.retire_valid !== 1'b0 || bus.retired_count !== 32'd1) begin bad++; $display("FAIL nop_single got=%b/%0d exp=0/1", bus.retire_valid, bus.retired_count); end
   endtask

   task automatic test_overflow();
      do_reset();
      drive(1'b1, 8'd2, 32'h30, 1'b1, 8'd3, 32'h31);
      step();
      total++; if (bus.retire_stall !== 1'b0) begin bad++; $display("FAIL stall_cnt2 got=%b exp=0", bus.retire_stall); end
      drive(1'b1, 8'd4, 32'h32, 1'b0, 8'd0, 32'h0);
      step();
      total++; if (bus.retire_stall !== 1'b1) begin bad++; $display("FAIL stall_cnt3 got=%b exp=1", bus.retire_stall); end
      drive(1'b1, 8'd6, 32'h33, 1'b1, 8'd7, 32'h34);
      step();
      idle();
      total++; if (bus.overflow !== 1'b1 || bus.retire_stall !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b/%b exp=1/1", bus.overflow, bus.retire_stall); end
      total++; if (bus.retire_pc !== 32'h30) begin bad++; $display("FAIL ovf_head got=%h exp=30", bus.retire_pc); end
      bus.retire_ready = 1'b1;
      step();
      total++; if (bus.retire_pc !== 32'h31 || bus.retire_stall !== 1'b1) begin bad++; $display("FAIL pop1 got=%h/%b exp=31/1", bus.retire_pc, bus.retire_stall); end
      step();
      total++; if (bus.retire_pc !== 32'h32 || bus.retire_stall !== 1'b0) begin bad++; $display("FAIL pop2 got=%h/%b exp=32/0", bus.retire_pc, bus.retire_stall); end
      step();
      total++; if (bus.retire_pc !== 32'h33) begin bad++; $display("FAIL pop3 got=%h exp=33", bus.retire_pc); end
      step();
      total++; if (bus.retire_valid !== 1'b0 || bus.retired_count !== 32'd4) begin bad++; $display("FAIL pop4 got=%b/%0d exp=0/4", bus.retire_valid, bus.retired_count); end
      step();
      total++; if (bus.retired_count !== 32'd4 || bus.overflow !== 1'b1 || bus.order_error !== 1'b0) begin bad++; $display("FAIL empty_ready got=%0d/%b/%b exp=4/1/0", bus.retired_count, bus.overflow, bus.order_error); end
   endtask

   task automatic test_order_error();
      do_reset();
      drive(1'b1, 8'd18, 32'h50, 1'b0, 8'd0, 32'h0);
      step();
      drive(1'b1, 8'd16, 32'h51, 1'b0, 8'd0, 32'h0);
      step();
      idle();
      total++; if (bus.order_error !== 1'b1) begin bad++; $display("FAIL oerr_set got=%b exp=1", bus.order_error); end
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      total++; if (bus.order_error !== 1'b1 || bus.retire_valid !== 1'b0) begin bad++; $display("FAIL oerr_flush got=%b/%b exp=1/0", bus.order_error, bus.retire_valid); end
      do_reset();
      total++; if (bus.order_error !== 1'b0) begin bad++; $display("FAIL oerr_reset got=%b exp=0", bus.order_error); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 8'd2, 32'h30, 1'b1, 8'd3, 32'h31);
      step();
      drive(1'b1, 8'd4, 32'h32, 1'b0, 8'd0, 32'h0);
      step();
      bus.flush = 1'b1;
      bus.retire_ready = 1'b1;
      drive(1'b1, 8'd6, 32'h33, 1'b1, 8'd7, 32'h34);
      step();
      bus.flush = 1'b0;
      bus.retire_ready = 1'b0;
      total++; if (bus.retire_valid !== 1'b0 || bus.retired_count !== 32'd1 || bus.retire_stall !== 1'b0) begin bad++; $display("FAIL flush_state got=%b/%0d/%b exp=0/1/0", bus.retire_valid, bus.retired_count, bus.retire_stall); end
      drive(1'b1, 8'd4, 32'h52, 1'b0, 8'd0, 32'h0);
      step();
      idle();
      total++; if (bus.retire_pc !== 32'h52 || bus.order_error !== 1'b0) begin bad++; $display("FAIL flush_repush got=%h/%b exp=52/0", bus.retire_pc, bus.order_error); end
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1'b1, 8'd254, 32'h60, 1'b0, 8'd0, 32'h0);
      step();
      drive(1'b1, 8'd0, 32'h61, 1'b0, 8'd0, 32'h0);
      step();
      idle();
      total++; if (bus.order_error !== 1'b0) begin bad++; $display("FAIL wrap_seq got=%b exp=0", bus.order_error); end
      do_reset();
      drive(1'b1, 8'd0, 32'h71, 1'b1, 8'd254, 32'h70);
      step();
      idle();
      total++; if (bus.retire_pc !== 32'h70) begin bad++; $display("FAIL wrap_pair_first got=%h exp=70", bus.retire_pc); end
      bus.retire_ready = 1'b1;
      step();
      total++; if (bus.retire_pc !== 32'h71 || bus.order_error !== 1'b0) begin bad++; $display("FAIL wrap_pair_second got=%h/%b exp=71/0", bus.retire_pc, bus.order_error); end
   endtask

   task automatic test_equal_ids();
      do_reset();
      drive(1'b1, 8'd20, 32'h80, 1'b1, 8'd20, 32'h81);
      step();
      idle();
      total++; if (bus.order_error !== 1'b1 || bus.retire_pc !== 32'h80) begin bad++; $display("FAIL equal_ids got=%b/%h exp=1/80", bus.order_error, bus.retire_pc); end
   endtask

   initial begin
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.retire_ready = 1'b0;
      idle();
      test_reset();
      test_same_group();
      test_nop();
      test_overflow();
      test_order_error();
      test_flush();
      test_wrap();
      test_equal_ids();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
